rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
Reset/preset sequencer for banks of set/resettable D flip-flops. It synchronises the external async reset deassertion and releases N_DOM flip-flop domains in a fixed staggered order. It also serves soft-reset and preset (set_n) requests at run time. It sits between the board-level reset and the set_n/reset_n inputs of the flip-flop banks.

Parameters:
N_DOM, 4, number of flip-flop domains driven (>=2)
SYNC_STAGES, 2, reset-deassert synchroniser depth (>=2)
GAP, 8, clk cycles between consecutive domain releases (>=1)
HOLD, 4, clk cycles a soft reset or preset pulse is held (>=1)
CNT_W, 5, counter width; must hold max(GAP, HOLD)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
soft_req  input  1  soft-reset request, level sampled on clk
preset_req  input  1  preset request, level sampled on clk
reset_n_out  output  N_DOM  active-low reset to domain k (bit k)
set_n_out  output  N_DOM  active-low set to domain k (bit k)
busy  output  1  high whenever FSM not in RUN
soft_ack  output  1  one-cycle pulse on completion of a soft reset

Behaviour:
- Interface: one clock, clk. reset_n is asynchronous and active-low.
- reset_n low (any time, mid-operation included):
  - immediately and asynchronously drive reset_n_out=0 (all bits), set_n_out=all 1, busy=1, soft_ack=0
  - synchroniser cleared, FSM=RESET, counter=0
- Deassert path: reset_n high is shifted through SYNC_STAGES flops. FSM leaves RESET on the first edge after the synchroniser output is high.
- States: RESET, RELEASE, RUN, SOFT_HOLD, PRESET_HOLD. All outputs are registered.
- RESET -> RELEASE at edge T0:
  - reset_n_out[0] rises at T0
  - reset_n_out[k] rises at T0 + k*GAP, ascending index order
  - a released bit stays high until the next reset event
- RELEASE -> RUN at T0 + (N_DOM-1)*GAP + 1; busy falls at that edge.
- With defaults, releases occur at T0, T0+8, T0+16, T0+24 and busy falls at T0+25.
- RUN, soft_req=1 sampled at edge E -> SOFT_HOLD:
  - reset_n_out=all 0 from E
  - busy=1
  - after HOLD cycles, at E+HOLD, enter RELEASE (new T0=E+HOLD) with the same stagger
  - on reaching RUN, soft_ack=1 for exactly one cycle
- RUN, preset_req=1 sampled at E -> PRESET_HOLD:
  - set_n_out=all 0 from E to E+HOLD
  - reset_n_out unchanged (all 1)
  - busy=1; at E+HOLD, set_n_out=all 1 and state=RUN
- Simultaneous soft_req and preset_req in RUN: soft reset wins; preset_req is dropped.
- Requests sampled outside RUN are ignored, not queued. A request still high when RUN is re-entered is taken on the next edge.
- Invariant: set_n_out[k] and reset_n_out[k] are never both 0 for any k. set_n_out is all 1 in every state except PRESET_HOLD.
- Counter wraps never: it is reloaded on every state entry.
- soft_ack is never asserted after a hardware reset release.

Test Plan:
- Power-on: reset_n=0 for 3 cycles, release mid-cycle -> reset_n_out=0000 until synchroniser completes; bits rise in order 0,1,2,3 spaced 8 cycles apart; busy falls 25 cycles after the first release; soft_ack stays 0.
- Soft reset: in RUN, soft_req high 1 cycle -> reset_n_out=0000 for 4 cycles, busy=1, then staggered re-release; a single soft_ack pulse when busy falls.
- Preset: in RUN, preset_req high 1 cycle -> set_n_out=0000 for 4 cycles, reset_n_out stays 1111, then set_n_out=1111 and busy=0; soft_ack=0.
- Simultaneous soft_req=preset_req=1 in RUN -> soft-reset sequence only; set_n_out stays 1111 throughout.
- Async reset mid-RELEASE (after 2 domains released) -> reset_n_out=0000 within the same cycle, with no clk edge needed; full sequence restarts from domain 0 after deassert.
- Requests during busy: soft_req pulsed during RELEASE and preset_req during SOFT_HOLD -> both ignored; a held-high preset_req is served on the first RUN cycle.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staggered reset/preset sequencer (clk, reset_n, soft_req, preset_req -> reset_n_out, set_n_out, busy, soft_ack)
module rst_seq_ctrl #(
  parameter int N_DOM       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int GAP         = 8,
  parameter int HOLD        = 4,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             soft_req,
  input  logic             preset_req,
  output logic [N_DOM-1:0] reset_n_out,
  output logic [N_DOM-1:0] set_n_out,
  output logic             busy,
  output logic             soft_ack
);
  typedef enum logic [2:0] {RESET, RELEASE, RUN, SOFT_HOLD, PRESET_HOLD} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_DOM-1:0]       rst_q, rst_d, set_q, set_d;
  logic                   busy_q, busy_d, ack_q, ack_d, soft_q, soft_d;
  localparam logic [N_DOM-1:0] FIRST = N_DOM'(1);
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d = state_q;
    cnt_d   = '0;
    rst_d   = rst_q;
    set_d   = '1;
    ack_d   = 1'b0;
    soft_d  = soft_q;
    case (state_q)
      RESET:
        if (sync_q[SYNC_STAGES-1]) begin
          state_d = RELEASE;
          rst_d   = FIRST;
        end
      RELEASE:
        if (&rst_q) begin
          state_d = RUN;
          ack_d   = soft_q;
          soft_d  = 1'b0;
        end else if (cnt_q == CNT_W'(GAP - 1)) rst_d = {rst_q[N_DOM-2:0], 1'b1};
        else cnt_d = cnt_q + 1'b1;
      RUN:
        if (soft_req) begin
          state_d = SOFT_HOLD;
          rst_d   = '0;
          soft_d  = 1'b1;
        end else if (preset_req) begin
          state_d = PRESET_HOLD;
          set_d   = '0;
        end
      SOFT_HOLD:
        if (cnt_q == CNT_W'(HOLD - 1)) begin
          state_d = RELEASE;
          rst_d   = FIRST;
        end else cnt_d = cnt_q + 1'b1;
      PRESET_HOLD:
        if (cnt_q == CNT_W'(HOLD - 1)) state_d = RUN;
        else begin
          cnt_d = cnt_q + 1'b1;
          set_d = '0;
        end
      default: state_d = RESET;
    endcase
    busy_d = state_d != RUN;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= RESET;
      cnt_q   <= '0;
      rst_q   <= '0;
      set_q   <= '1;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
      soft_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      set_q   <= set_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      soft_q  <= soft_d;
    end
  assign reset_n_out = rst_q;
  assign set_n_out   = set_q;
  assign busy        = busy_q;
  assign soft_ack    = ack_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: scoreboard bench checking every output change against expected cycle/value
module tb_rst_seq_ctrl;
  logic       clk = 1'b0, reset_n, soft_req, preset_req;
  logic [3:0] reset_n_out, set_n_out;
  logic       busy, soft_ack;
  int         cyc = 0, n_chk = 0, n_fail = 0;
  bit         mon_en = 1'b0;
  logic [9:0] prev;
  typedef struct {int cyc; logic [9:0] val;} exp_t;
  exp_t       exp_q[$];
  rst_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .soft_req(soft_req), .preset_req(preset_req),
    .reset_n_out(reset_n_out), .set_n_out(set_n_out), .busy(busy), .soft_ack(soft_ack)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (mon_en) begin
      logic [9:0] cur;
      exp_t e;
      cur = {reset_n_out, set_n_out, busy, soft_ack};
      n_chk++;
      if ((~reset_n_out & ~set_n_out) != 4'b0) begin
        n_fail++;
        $display("FAIL invariant cyc=%0d reset_n_out=%b set_n_out=%b", cyc, reset_n_out, set_n_out);
      end
      if (cur !== prev) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got=%b (rst,set,busy,ack) want=no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            n_fail++;
            $display("FAIL output_change got cyc=%0d val=%b want cyc=%0d val=%b", cyc, cur, e.cyc, e.val);
          end
        end
        prev = cur;
      end
    end
  task automatic push(input int c, input logic [3:0] r, input logic [3:0] s, input logic b, input logic a);
    exp_t e;
    e.cyc = c;
    e.val = {r, s, b, a};
    exp_q.push_back(e);
  endtask
  task automatic push_release(input int t0);
    push(t0,      4'b0001, 4'b1111, 1'b1, 1'b0);
    push(t0 + 8,  4'b0011, 4'b1111, 1'b1, 1'b0);
    push(t0 + 16, 4'b0111, 4'b1111, 1'b1, 1'b0);
    push(t0 + 24, 4'b1111, 4'b1111, 1'b1, 1'b0);
  endtask
  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic drain(input string name);
    int b = 0;
    while (exp_q.size() != 0 && b < 300) begin
      @(negedge clk);
      b++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout pending=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(negedge clk);
  endtask
  task automatic pulse_soft(output int e);
    @(negedge clk);
    e = cyc + 1;
    soft_req = 1'b1;
    push(e, 4'b0000, 4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    soft_req = 1'b0;
  endtask
  initial begin
    int e, t0;
    reset_n = 1'b1;
    soft_req = 1'b0;
    preset_req = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({reset_n_out, set_n_out, busy, soft_ack} !== 10'b0000_1111_1_0) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=%b", {reset_n_out, set_n_out, busy, soft_ack}, 10'b0000_1111_1_0);
    end
    prev = {reset_n_out, set_n_out, busy, soft_ack};
    mon_en = 1'b1;
    to_cyc(3);
    reset_n = 1'b1;
    push_release(6);
    push(31, 4'b1111, 4'b1111, 1'b0, 1'b0);
    drain("power_on");
    pulse_soft(e);
    push_release(e + 4);
    push(e + 29, 4'b1111, 4'b1111, 1'b0, 1'b1);
    push(e + 30, 4'b1111, 4'b1111, 1'b0, 1'b0);
    drain("soft_reset");
    @(negedge clk);
    e = cyc + 1;
    preset_req = 1'b1;
    push(e, 4'b1111, 4'b0000, 1'b1, 1'b0);
    push(e + 4, 4'b1111, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    preset_req = 1'b0;
    drain("preset");
    @(negedge clk);
    e = cyc + 1;
    soft_req = 1'b1;
    preset_req = 1'b1;
    push(e, 4'b0000, 4'b1111, 1'b1, 1'b0);
    push_release(e + 4);
    push(e + 29, 4'b1111, 4'b1111, 1'b0, 1'b1);
    push(e + 30, 4'b1111, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    soft_req = 1'b0;
    preset_req = 1'b0;
    drain("simultaneous");
    pulse_soft(e);
    t0 = e + 4;
    push(t0, 4'b0001, 4'b1111, 1'b1, 1'b0);
    push(t0 + 8, 4'b0011, 4'b1111, 1'b1, 1'b0);
    to_cyc(t0 + 9);
    @(posedge clk);
    #2;
    push(cyc, 4'b0000, 4'b1111, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (reset_n_out !== 4'b0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset got rst=%b busy=%b want rst=0000 busy=1", reset_n_out, busy);
    end
    to_cyc(cyc + 2);
    reset_n = 1'b1;
    t0 = cyc + 3;
    push_release(t0);
    push(t0 + 25, 4'b1111, 4'b1111, 1'b0, 1'b0);
    to_cyc(t0 + 3);
    soft_req = 1'b1;
    @(negedge clk);
    soft_req = 1'b0;
    drain("async_restart");
    pulse_soft(e);
    preset_req = 1'b1;
    @(negedge clk);
    preset_req = 1'b0;
    t0 = e + 4;
    push_release(t0);
    push(t0 + 25, 4'b1111, 4'b1111, 1'b0, 1'b1);
    push(t0 + 26, 4'b1111, 4'b0000, 1'b1, 1'b0);
    push(t0 + 30, 4'b1111, 4'b1111, 1'b0, 1'b0);
    to_cyc(t0 + 10);
    preset_req = 1'b1;
    to_cyc(t0 + 26);
    preset_req = 1'b0;
    drain("busy_requests");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
